// File: rtl/uart_yukleyici_pkg.sv
// Shared constants and state encoding for the UART-driven bus loader.
package uart_yukleyici_pkg;

    localparam logic [7:0] YUKLE_CMD_YAZ = 8'h57;
    localparam logic [7:0] YUKLE_CMD_OKU = 8'h52;
    localparam logic [7:0] YUKLE_ONAY    = 8'h4B;
    localparam logic [7:0] YUKLE_HATA    = 8'h3F;

    typedef enum logic [2:0] {
        BOSTA       = 3'd0,
        ADRES_AL    = 3'd1,
        VERI_AL     = 3'd2,
        ISTEK       = 3'd3,
        YANIT_BEKLE = 3'd4,
        GONDER      = 3'd5
    } durum_t;

    function automatic logic komut_mu(input logic [7:0] bayt);
        return (bayt == YUKLE_CMD_YAZ) || (bayt == YUKLE_CMD_OKU);
    endfunction

endpackage

// File: rtl/uart_yukleyici.sv
// UART byte-stream bus initiator: parses read/write packets, issues one cek
// request per packet and streams the acknowledge or read data back to tx.
module uart_yukleyici
    import uart_yukleyici_pkg::*;
#(
    parameter int ADRES_BIT   = 32,
    parameter int VERI_BIT    = 32,
    parameter int ZAMAN_ASIMI = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           rx_bayt_i,
    input  logic                 rx_gecerli_i,
    output logic                 rx_hazir_o,
    output logic [7:0]           tx_bayt_o,
    output logic                 tx_gecerli_o,
    input  logic                 tx_hazir_i,
    output logic [ADRES_BIT-1:0] cek_adres_o,
    output logic [VERI_BIT-1:0]  cek_veri_o,
    output logic                 cek_yaz_o,
    output logic                 cek_gecerli_o,
    input  logic                 cek_hazir_i,
    input  logic [VERI_BIT-1:0]  yanit_veri_i,
    input  logic                 yanit_gecerli_i,
    output logic                 yanit_hazir_o,
    output logic                 mesgul_o
);

    localparam int ZW = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam logic [ZW-1:0] ZAMAN_SON = ZW'(ZAMAN_ASIMI - 1);

    durum_t              durum;
    logic [1:0]          sayac;
    logic [ZW-1:0]       zaman;
    logic [VERI_BIT-1:0] tx_kaydirici;
    logic [2:0]          tx_sayi;

    assign tx_bayt_o = tx_kaydirici[7:0];

    // Every handshake flag is a register updated on the transition into its state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum         <= BOSTA;
            sayac         <= '0;
            zaman         <= '0;
            tx_kaydirici  <= '0;
            tx_sayi       <= '0;
            cek_adres_o   <= '0;
            cek_veri_o    <= '0;
            cek_yaz_o     <= 1'b0;
            cek_gecerli_o <= 1'b0;
            tx_gecerli_o  <= 1'b0;
            yanit_hazir_o <= 1'b0;
            rx_hazir_o    <= 1'b1;
            mesgul_o      <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (rx_gecerli_i) begin
                        mesgul_o <= 1'b1;
                        if (komut_mu(rx_bayt_i)) begin
                            cek_yaz_o <= (rx_bayt_i == YUKLE_CMD_YAZ);
                            sayac     <= '0;
                            zaman     <= '0;
                            durum     <= ADRES_AL;
                        end else begin
                            tx_kaydirici <= VERI_BIT'(YUKLE_HATA);
                            tx_sayi      <= 3'd1;
                            rx_hazir_o   <= 1'b0;
                            tx_gecerli_o <= 1'b1;
                            durum        <= GONDER;
                        end
                    end
                end
                ADRES_AL: begin
                    // An arriving byte outranks an expiring timeout in the same cycle.
                    if (rx_gecerli_i) begin
                        cek_adres_o <= {rx_bayt_i, cek_adres_o[ADRES_BIT-1:8]};
                        sayac       <= sayac + 2'd1;
                        zaman       <= '0;
                        if (sayac == 2'd3) begin
                            if (cek_yaz_o) begin
                                durum <= VERI_AL;
                            end else begin
                                rx_hazir_o    <= 1'b0;
                                cek_gecerli_o <= 1'b1;
                                durum         <= ISTEK;
                            end
                        end
                    end else if (zaman == ZAMAN_SON) begin
                        mesgul_o <= 1'b0;
                        durum    <= BOSTA;
                    end else begin
                        zaman <= zaman + 1'b1;
                    end
                end
                VERI_AL: begin
                    if (rx_gecerli_i) begin
                        cek_veri_o <= {rx_bayt_i, cek_veri_o[VERI_BIT-1:8]};
                        sayac      <= sayac + 2'd1;
                        zaman      <= '0;
                        if (sayac == 2'd3) begin
                            rx_hazir_o    <= 1'b0;
                            cek_gecerli_o <= 1'b1;
                            durum         <= ISTEK;
                        end
                    end else if (zaman == ZAMAN_SON) begin
                        mesgul_o <= 1'b0;
                        durum    <= BOSTA;
                    end else begin
                        zaman <= zaman + 1'b1;
                    end
                end
                ISTEK: begin
                    if (cek_hazir_i) begin
                        cek_gecerli_o <= 1'b0;
                        if (cek_yaz_o) begin
                            tx_kaydirici <= VERI_BIT'(YUKLE_ONAY);
                            tx_sayi      <= 3'd1;
                            tx_gecerli_o <= 1'b1;
                            durum        <= GONDER;
                        end else begin
                            yanit_hazir_o <= 1'b1;
                            durum         <= YANIT_BEKLE;
                        end
                    end
                end
                YANIT_BEKLE: begin
                    if (yanit_gecerli_i) begin
                        tx_kaydirici  <= yanit_veri_i;
                        tx_sayi       <= 3'd4;
                        yanit_hazir_o <= 1'b0;
                        tx_gecerli_o  <= 1'b1;
                        durum         <= GONDER;
                    end
                end
                GONDER: begin
                    if (tx_hazir_i) begin
                        tx_kaydirici <= tx_kaydirici >> 8;
                        tx_sayi      <= tx_sayi - 3'd1;
                        if (tx_sayi == 3'd1) begin
                            tx_gecerli_o <= 1'b0;
                            rx_hazir_o   <= 1'b1;
                            mesgul_o     <= 1'b0;
                            durum        <= BOSTA;
                        end
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_yukleyici.sv
// Scoreboard bench for uart_yukleyici: stimulus pushes expected requests and
// tx bytes, a negedge monitor pops and compares on every completed handshake.
module tb_uart_yukleyici;

    typedef struct packed {
        logic [31:0] adres;
        logic [31:0] veri;
        logic        yaz;
        logic        veri_var;
    } istek_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_bayt = '0;
    logic        rx_gecerli = 1'b0;
    logic        rx_hazir;
    logic [7:0]  tx_bayt;
    logic        tx_gecerli;
    logic        tx_hazir = 1'b0;
    logic [31:0] cek_adres;
    logic [31:0] cek_veri;
    logic        cek_yaz;
    logic        cek_gecerli;
    logic        cek_hazir = 1'b0;
    logic [31:0] yanit_veri = '0;
    logic        yanit_gecerli = 1'b0;
    logic        yanit_hazir;
    logic        mesgul;

    int n_vec = 0;
    int n_err = 0;

    istek_t     istek_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_yukleyici #(
        .ADRES_BIT  (32),
        .VERI_BIT   (32),
        .ZAMAN_ASIMI(16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_bayt_i      (rx_bayt),
        .rx_gecerli_i   (rx_gecerli),
        .rx_hazir_o     (rx_hazir),
        .tx_bayt_o      (tx_bayt),
        .tx_gecerli_o   (tx_gecerli),
        .tx_hazir_i     (tx_hazir),
        .cek_adres_o    (cek_adres),
        .cek_veri_o     (cek_veri),
        .cek_yaz_o      (cek_yaz),
        .cek_gecerli_o  (cek_gecerli),
        .cek_hazir_i    (cek_hazir),
        .yanit_veri_i   (yanit_veri),
        .yanit_gecerli_i(yanit_gecerli),
        .yanit_hazir_o  (yanit_hazir),
        .mesgul_o       (mesgul)
    );

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_vec++;
        if (gercek !== beklenen) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    // Monitor: handshakes seen at negedge complete on the following posedge.
    logic       onceki_tx_v = 1'b0;
    logic [7:0] onceki_tx_b = '0;
    logic       onceki_cek_v = 1'b0;
    istek_t     onceki_cek = '0;

    always @(negedge clk) begin
        if (rst) begin
            onceki_tx_v  = 1'b0;
            onceki_cek_v = 1'b0;
        end else begin
            if (onceki_tx_v) begin
                chk("tx_valid_held", {31'd0, tx_gecerli}, 32'd1);
                chk("tx_byte_stable", {24'd0, tx_bayt}, {24'd0, onceki_tx_b});
            end
            if (onceki_cek_v) begin
                chk("cek_valid_held", {31'd0, cek_gecerli}, 32'd1);
                chk("cek_adres_stable", cek_adres, onceki_cek.adres);
                chk("cek_veri_stable", cek_veri, onceki_cek.veri);
                chk("cek_yaz_stable", {31'd0, cek_yaz}, {31'd0, onceki_cek.yaz});
            end
            if (cek_gecerli && cek_hazir) begin
                if (istek_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_request: got adres=%h yaz=%b, expected none", cek_adres, cek_yaz);
                end else begin
                    istek_t e;
                    e = istek_q.pop_front();
                    chk("req_adres", cek_adres, e.adres);
                    chk("req_yaz", {31'd0, cek_yaz}, {31'd0, e.yaz});
                    if (e.veri_var) chk("req_veri", cek_veri, e.veri);
                end
            end
            if (tx_gecerli && tx_hazir) begin
                if (tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_tx: got %h, expected none", tx_bayt);
                end else begin
                    logic [7:0] b;
                    b = tx_q.pop_front();
                    chk("tx_byte", {24'd0, tx_bayt}, {24'd0, b});
                end
            end
            onceki_tx_v  = tx_gecerli && !tx_hazir;
            onceki_tx_b  = tx_bayt;
            onceki_cek_v = cek_gecerli && !cek_hazir;
            onceki_cek   = '{adres: cek_adres, veri: cek_veri, yaz: cek_yaz, veri_var: 1'b1};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_bayt    = b;
        rx_gecerli = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_hazir) ok = 1'b1;
        end
        tick();
        rx_gecerli = 1'b0;
        chk("rx_accept", {31'd0, ok}, 32'd1);
    endtask

    // Bytes are given in wire order, first byte in the most significant used position.
    task automatic send_pkt(input logic [71:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(p[8*i +: 8]);
    endtask

    task automatic wait_idle(input bit toggle);
        bit bos;
        bos = 1'b0;
        for (int i = 0; i < 60 && !bos; i++) begin
            tick();
            if (toggle) tx_hazir = ~tx_hazir;
            @(negedge clk);
            if (!mesgul) bos = 1'b1;
        end
        chk("idle_reached", {31'd0, mesgul}, 32'd0);
        tick();
    endtask

    task automatic wait_yanit();
        bit gordu;
        gordu = 1'b0;
        for (int i = 0; i < 40 && !gordu; i++) begin
            @(negedge clk);
            if (yanit_hazir) gordu = 1'b1;
        end
        chk("yanit_hazir_up", {31'd0, yanit_hazir}, 32'd1);
        tick();
    endtask

    task automatic reset_outputs_check(input string ad);
        @(negedge clk);
        chk({ad, "_cek_gecerli"}, {31'd0, cek_gecerli}, 32'd0);
        chk({ad, "_tx_gecerli"}, {31'd0, tx_gecerli}, 32'd0);
        chk({ad, "_yanit_hazir"}, {31'd0, yanit_hazir}, 32'd0);
        chk({ad, "_rx_hazir"}, {31'd0, rx_hazir}, 32'd1);
        chk({ad, "_mesgul"}, {31'd0, mesgul}, 32'd0);
        chk({ad, "_tx_bayt"}, {24'd0, tx_bayt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_outputs_check("reset");
        chk("reset_adres", cek_adres, 32'd0);
        chk("reset_veri", cek_veri, 32'd0);

        // Write packet, bus and transmitter always ready.
        tick();
        cek_hazir = 1'b1;
        tx_hazir  = 1'b1;
        istek_q.push_back('{adres: 32'h2000_0010, veri: 32'hDEAD_BEEF, yaz: 1'b1, veri_var: 1'b1});
        tx_q.push_back(8'h4B);
        send_pkt(72'h57_10_00_00_20_EF_BE_AD_DE, 9);
        @(negedge clk);
        chk("wr_cek_latency", {31'd0, cek_gecerli}, 32'd1);
        @(negedge clk);
        chk("wr_tx_latency", {31'd0, tx_gecerli}, 32'd1);
        chk("wr_tx_bayt", {24'd0, tx_bayt}, 32'h4B);
        @(negedge clk);
        chk("wr_mesgul_fall", {31'd0, mesgul}, 32'd0);
        tick();

        // Read packet with a delayed bus accept and a toggling transmitter.
        cek_hazir = 1'b0;
        tx_hazir  = 1'b0;
        istek_q.push_back('{adres: 32'h2000_0004, veri: 32'h0, yaz: 1'b0, veri_var: 1'b0});
        send_pkt(72'h52_04_00_00_20, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rd_cek_held", {31'd0, cek_gecerli}, 32'd1);
            chk("rd_cek_yaz", {31'd0, cek_yaz}, 32'd0);
            chk("rd_cek_adres", cek_adres, 32'h2000_0004);
        end
        tick();
        cek_hazir = 1'b1;
        tick();
        cek_hazir = 1'b0;
        wait_yanit();
        yanit_veri    = 32'h1234_5678;
        yanit_gecerli = 1'b1;
        tx_q.push_back(8'h78);
        tx_q.push_back(8'h56);
        tx_q.push_back(8'h34);
        tx_q.push_back(8'h12);
        tick();
        yanit_gecerli = 1'b0;
        @(negedge clk);
        chk("rd_tx_latency", {31'd0, tx_gecerli}, 32'd1);
        chk("rd_tx_first", {24'd0, tx_bayt}, 32'h78);
        wait_idle(1'b1);
        chk("rd_tx_all_sent", tx_q.size(), 32'd0);

        // Unknown command, then a normal write.
        tx_hazir  = 1'b1;
        cek_hazir = 1'b1;
        tx_q.push_back(8'h3F);
        send_byte(8'hAA);
        wait_idle(1'b0);
        istek_q.push_back('{adres: 32'h0000_0100, veri: 32'h1122_3344, yaz: 1'b1, veri_var: 1'b1});
        tx_q.push_back(8'h4B);
        send_pkt(72'h57_00_01_00_00_44_33_22_11, 9);
        wait_idle(1'b0);

        // Timeout after a partial packet: exactly 16 idle cycles to return to BOSTA.
        send_pkt(72'h57_10_00, 3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("to_still_busy", {31'd0, mesgul}, 32'd1);
        @(negedge clk);
        chk("to_expired", {31'd0, mesgul}, 32'd0);
        chk("to_rx_hazir", {31'd0, rx_hazir}, 32'd1);
        tick();
        istek_q.push_back('{adres: 32'h4000_0008, veri: 32'h0, yaz: 1'b0, veri_var: 1'b0});
        send_pkt(72'h52_08_00_00_40, 5);
        wait_yanit();
        yanit_veri    = 32'h0BAD_F00D;
        yanit_gecerli = 1'b1;
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'hF0);
        tx_q.push_back(8'hAD);
        tx_q.push_back(8'h0B);
        tick();
        yanit_gecerli = 1'b0;
        wait_idle(1'b0);

        // A byte arriving on the last idle cycle before expiry is accepted.
        istek_q.push_back('{adres: 32'h0000_1234, veri: 32'h1234_5678, yaz: 1'b1, veri_var: 1'b1});
        tx_q.push_back(8'h4B);
        send_pkt(72'h57_34, 2);
        repeat (15) @(posedge clk);
        #1;
        send_pkt(72'h12_00_00_78_56_34_12, 7);
        wait_idle(1'b0);

        // Reset while holding a request in ISTEK.
        cek_hazir = 1'b0;
        send_pkt(72'h57_00_00_00_30_04_03_02_01, 9);
        @(negedge clk);
        chk("rst_istek_pending", {31'd0, cek_gecerli}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_outputs_check("rst_istek");
        tick();

        // Reset in the middle of sending read data.
        cek_hazir = 1'b1;
        tx_hazir  = 1'b0;
        istek_q.push_back('{adres: 32'h1000_000C, veri: 32'h0, yaz: 1'b0, veri_var: 1'b0});
        send_pkt(72'h52_0C_00_00_10, 5);
        wait_yanit();
        yanit_veri    = 32'hCAFE_F00D;
        yanit_gecerli = 1'b1;
        tick();
        yanit_gecerli = 1'b0;
        tx_q.push_back(8'h0D);
        tx_hazir = 1'b1;
        tick();
        tx_hazir = 1'b0;
        @(negedge clk);
        chk("rst_gonder_pending", {31'd0, tx_gecerli}, 32'd1);
        chk("rst_gonder_next", {24'd0, tx_bayt}, 32'hF0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_outputs_check("rst_gonder");
        tick();

        // Recovery write after both resets.
        cek_hazir = 1'b1;
        tx_hazir  = 1'b1;
        istek_q.push_back('{adres: 32'hFFFF_FFFF, veri: 32'h8000_0000, yaz: 1'b1, veri_var: 1'b1});
        tx_q.push_back(8'h4B);
        send_pkt(72'h57_FF_FF_FF_FF_00_00_00_80, 9);
        wait_idle(1'b0);

        chk("req_queue_drained", istek_q.size(), 32'd0);
        chk("tx_queue_drained", tx_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
